// File: rtl/sll_access_arbiter.sv
// Round-robin front end that shares one singly linked list engine between NUM_REQ clients.
// One operation in flight at a time; a watchdog answers with a timeout if the list stalls.
module sll_access_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [3*NUM_REQ-1:0]            req_op,
  input  logic [DATA_WIDTH*NUM_REQ-1:0]   req_data,
  input  logic [ADDR_WIDTH*NUM_REQ-1:0]   req_addr,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic [NUM_REQ-1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]           rsp_data,
  output logic [ADDR_WIDTH-1:0]           rsp_next_addr,
  output logic                            rsp_fault,
  output logic                            rsp_timeout,
  output logic                            busy,
  output logic [$clog2(NUM_REQ)-1:0]      grant_id,
  output logic [2:0]                      ll_op,
  output logic [DATA_WIDTH-1:0]           ll_data_in,
  output logic [ADDR_WIDTH-1:0]           ll_addr_in,
  output logic                            ll_op_start,
  input  logic                            ll_op_done,
  input  logic [DATA_WIDTH-1:0]           ll_data_out,
  input  logic [ADDR_WIDTH-1:0]           ll_next_node_addr,
  input  logic                            ll_fault
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT_CYC);

  typedef enum logic [1:0] {IDLE, BUSY, RESP, DRAIN} state_t;

  state_t          state, state_nxt;
  logic [GW-1:0]   rr_ptr;
  logic [GW-1:0]   winner;
  logic            found;
  logic [CW-1:0]   count;
  logic            accept, capture, timeout, clr_start;

  function automatic logic [GW-1:0] wrap_idx(input int v);
    return GW'(v % NUM_REQ);
  endfunction

  // First requester at or above rr_ptr, wrapping around.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[wrap_idx(int'(rr_ptr) + i)]) begin
        found  = 1'b1;
        winner = wrap_idx(int'(rr_ptr) + i);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    rsp_valid = '0;
    accept    = 1'b0;
    capture   = 1'b0;
    timeout   = 1'b0;
    clr_start = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          accept            = 1'b1;
          req_ready[winner] = 1'b1;
          state_nxt         = BUSY;
        end
      end
      BUSY: begin
        // A completion on the last watchdog cycle still counts as a normal response.
        if (ll_op_done) begin
          capture   = 1'b1;
          clr_start = 1'b1;
          state_nxt = RESP;
        end else if (count == CW'(TIMEOUT_CYC - 1)) begin
          timeout   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        rsp_valid[grant_id] = 1'b1;
        // rsp_timeout doubles as the "operation still outstanding" flag here.
        if (rsp_timeout && !ll_op_done) begin
          state_nxt = DRAIN;
        end else begin
          state_nxt = IDLE;
          clr_start = rsp_timeout;
        end
      end
      DRAIN: begin
        if (ll_op_done) begin
          clr_start = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      grant_id      <= '0;
      count         <= '0;
      ll_op         <= '0;
      ll_data_in    <= '0;
      ll_addr_in    <= '0;
      ll_op_start   <= 1'b0;
      rsp_data      <= '0;
      rsp_next_addr <= '0;
      rsp_fault     <= 1'b0;
      rsp_timeout   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == BUSY) begin
        count <= count + 1'b1;
      end
      if (accept) begin
        ll_op       <= req_op[3*int'(winner) +: 3];
        ll_data_in  <= req_data[DATA_WIDTH*int'(winner) +: DATA_WIDTH];
        ll_addr_in  <= req_addr[ADDR_WIDTH*int'(winner) +: ADDR_WIDTH];
        ll_op_start <= 1'b1;
        grant_id    <= winner;
        rr_ptr      <= wrap_idx(int'(winner) + 1);
        count       <= '0;
      end
      if (capture) begin
        rsp_data      <= ll_data_out;
        rsp_next_addr <= ll_next_node_addr;
        rsp_fault     <= ll_fault;
        rsp_timeout   <= 1'b0;
      end
      if (timeout) begin
        rsp_data      <= '0;
        rsp_next_addr <= '0;
        rsp_fault     <= 1'b1;
        rsp_timeout   <= 1'b1;
      end
      if (clr_start) begin
        ll_op_start <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_sll_access_arbiter.sv
// Directed bench for sll_access_arbiter; the bench itself plays the list engine.
module tb_sll_access_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [11:0] req_op;
  logic [31:0] req_data;
  logic [15:0] req_addr;
  logic [3:0]  req_ready;
  logic [3:0]  rsp_valid;
  logic [7:0]  rsp_data;
  logic [3:0]  rsp_next_addr;
  logic        rsp_fault;
  logic        rsp_timeout;
  logic        busy;
  logic [1:0]  grant_id;
  logic [2:0]  ll_op;
  logic [7:0]  ll_data_in;
  logic [3:0]  ll_addr_in;
  logic        ll_op_start;
  logic        ll_op_done;
  logic [7:0]  ll_data_out;
  logic [3:0]  ll_next_node_addr;
  logic        ll_fault;

  int total = 0;
  int bad   = 0;

  sll_access_arbiter #(
    .NUM_REQ(4), .DATA_WIDTH(8), .ADDR_WIDTH(4), .TIMEOUT_CYC(8)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_op(req_op), .req_data(req_data), .req_addr(req_addr),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_next_addr(rsp_next_addr), .rsp_fault(rsp_fault), .rsp_timeout(rsp_timeout),
    .busy(busy), .grant_id(grant_id),
    .ll_op(ll_op), .ll_data_in(ll_data_in), .ll_addr_in(ll_addr_in),
    .ll_op_start(ll_op_start), .ll_op_done(ll_op_done), .ll_data_out(ll_data_out),
    .ll_next_node_addr(ll_next_node_addr), .ll_fault(ll_fault)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_op = '0; req_data = '0; req_addr = '0;
    ll_op_done = 1'b0; ll_data_out = '0; ll_next_node_addr = '0; ll_fault = 1'b0;
    tick(); tick();
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_start", ll_op_start, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_ll_op", ll_op, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_ready", req_ready, 0);
    rst = 1'b0;

    // Single read: req0 op=0 addr=2, list returns 0x5A.
    tick();
    req_valid = 4'b0001; req_op[2:0] = 3'd0; req_addr[3:0] = 4'd2; req_data[7:0] = 8'h11;
    #1;
    chk("rd_ready", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    #1;
    chk("rd_busy", busy, 1);
    chk("rd_start", ll_op_start, 1);
    chk("rd_addr", ll_addr_in, 2);
    chk("rd_op", ll_op, 0);
    tick();
    chk("rd_start_held", ll_op_start, 1);
    chk("rd_no_rsp", rsp_valid, 0);
    ll_op_done = 1'b1; ll_data_out = 8'h5A; ll_next_node_addr = 4'd3; ll_fault = 1'b0;
    tick();
    ll_op_done = 1'b0;
    #1;
    chk("rd_rsp_valid", rsp_valid, 4'b0001);
    chk("rd_rsp_data", rsp_data, 8'h5A);
    chk("rd_rsp_next", rsp_next_addr, 3);
    chk("rd_rsp_fault", rsp_fault, 0);
    chk("rd_rsp_to", rsp_timeout, 0);
    chk("rd_start_low", ll_op_start, 0);
    tick();
    chk("rd_idle_busy", busy, 0);
    chk("rd_idle_rsp", rsp_valid, 0);

    // Round robin from rr_ptr=0 with all four requesting.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_valid = 4'b1111;
    req_op = {3'd4, 3'd3, 3'd2, 3'd1};
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("rr_ready", req_ready, 4'b0001 << (k % 4));
      tick();
      chk("rr_grant", grant_id, k % 4);
      chk("rr_op", ll_op, (k % 4) + 1);
      chk("rr_start", ll_op_start, 1);
      ll_op_done = 1'b1; ll_data_out = 8'(k);
      tick();
      ll_op_done = 1'b0;
      chk("rr_rsp_valid", rsp_valid, 4'b0001 << (k % 4));
      chk("rr_start_gap", ll_op_start, 0);
      chk("rr_ready_resp", req_ready, 0);
      tick();
    end
    req_valid = '0;

    // Fault pass-through: req2 delete-by-value 0x77 on an empty list.
    req_valid = 4'b0100; req_op[8:6] = 3'd3; req_data[23:16] = 8'h77;
    #1;
    chk("flt_ready", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    chk("flt_data_in", ll_data_in, 8'h77);
    chk("flt_op", ll_op, 3);
    chk("flt_grant", grant_id, 2);
    ll_op_done = 1'b1; ll_fault = 1'b1; ll_data_out = 8'h42;
    tick();
    ll_op_done = 1'b0; ll_fault = 1'b0;
    chk("flt_rsp_valid", rsp_valid, 4'b0100);
    chk("flt_rsp_fault", rsp_fault, 1);
    chk("flt_rsp_to", rsp_timeout, 0);
    tick();

    // Timeout: rr_ptr=3, only req1 asks; the list never completes in time.
    req_valid = 4'b0010; ll_data_out = 8'hEE; ll_next_node_addr = 4'd9;
    #1;
    chk("to_ready", req_ready, 4'b0010);
    tick();
    req_valid = '0;
    for (int k = 0; k < 8; k++) begin
      chk("to_wait_rsp", rsp_valid, 0);
      tick();
    end
    chk("to_rsp_valid", rsp_valid, 4'b0010);
    chk("to_rsp_fault", rsp_fault, 1);
    chk("to_rsp_to", rsp_timeout, 1);
    chk("to_rsp_data", rsp_data, 0);
    chk("to_rsp_next", rsp_next_addr, 0);
    chk("to_start_held", ll_op_start, 1);
    tick();
    for (int k = 0; k < 4; k++) begin
      chk("dr_busy", busy, 1);
      chk("dr_start", ll_op_start, 1);
      chk("dr_no_rsp", rsp_valid, 0);
      tick();
    end
    ll_op_done = 1'b1;
    tick();
    ll_op_done = 1'b0;
    chk("dr_idle", busy, 0);
    chk("dr_start_low", ll_op_start, 0);
    chk("dr_no_extra_rsp", rsp_valid, 0);

    // Tie: op_done lands on the last watchdog cycle (rr_ptr=2, req2).
    req_valid = 4'b0100;
    #1;
    chk("tie_ready", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    for (int k = 0; k < 7; k++) tick();
    chk("tie_no_rsp_yet", rsp_valid, 0);
    ll_op_done = 1'b1; ll_data_out = 8'h99; ll_fault = 1'b0;
    tick();
    ll_op_done = 1'b0;
    chk("tie_rsp_valid", rsp_valid, 4'b0100);
    chk("tie_rsp_to", rsp_timeout, 0);
    chk("tie_rsp_fault", rsp_fault, 0);
    chk("tie_rsp_data", rsp_data, 8'h99);
    tick();
    chk("tie_no_drain", busy, 0);

    // Reset during an insert from req2 (rr_ptr=3 before, 3 after grant).
    req_valid = 4'b0100; req_op[8:6] = 3'd1;
    #1;
    chk("rb_ready", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    chk("rb_busy", busy, 1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rb_start", ll_op_start, 0);
    chk("rb_busy0", busy, 0);
    chk("rb_grant0", grant_id, 0);
    chk("rb_rsp", rsp_valid, 0);
    req_valid = 4'b1001;
    #1;
    chk("rb_rrptr0", req_ready, 4'b0001);
    req_valid = 4'b0010; req_op[5:3] = 3'd5;
    #1;
    chk("rb_req1_ready", req_ready, 4'b0010);
    tick();
    req_valid = '0;
    chk("rb_req1_grant", grant_id, 1);
    chk("rb_req1_op", ll_op, 5);
    ll_op_done = 1'b1;
    tick();
    ll_op_done = 1'b0;
    chk("rb_req1_rsp", rsp_valid, 4'b0010);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
